// File: rtl/led_ctrl_multi_pkg.sv
// Shared LED controller definitions: channel modes and the per-channel
// runtime configuration record.
package led_ctrl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'd0;
  localparam mode_t MODE_ON      = 2'd1;
  localparam mode_t MODE_BLINK   = 2'd2;
  localparam mode_t MODE_BREATHE = 2'd3;

  // Period is held at the widest supported size; narrower builds zero-extend.
  localparam int PER_W_MAX = 32;

  typedef struct packed {
    mode_t                mode;
    logic [PER_W_MAX-1:0] period;
  } cfg_t;

endpackage

// File: rtl/led_ctrl_multi_if.sv
// Runtime configuration bus of the LED controller: a one-cycle write strobe
// carrying channel index, mode and period.
interface led_ctrl_multi_if
  import led_ctrl_pkg::*;
#(
  parameter int PER_W = 16
);
  logic             cfg_wr;
  logic [3:0]       cfg_ch;
  mode_t            cfg_mode;
  logic [PER_W-1:0] cfg_period;

  modport master (output cfg_wr, output cfg_ch, output cfg_mode, output cfg_period);
  modport slave  (input  cfg_wr, input  cfg_ch, input  cfg_mode, input  cfg_period);
endinterface

// File: rtl/led_ctrl_multi_chan.sv
// One LED channel: runtime config, tick step counter, blink/breathe state and a
// registered raw "on" drive (before polarity inversion).
module led_chan
  import led_ctrl_pkg::*;
#(
  parameter int               PER_W          = 16,
  parameter int               PWM_W          = 8,
  parameter mode_t            DEFAULT_MODE   = MODE_BLINK,
  parameter logic [PER_W-1:0] DEFAULT_PERIOD = PER_W'(500)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             tick_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             wr_i,
  input  mode_t            mode_i,
  input  logic [PER_W-1:0] period_i,
  output logic             raw_on_o
);

  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

  cfg_t                 cfg_q, cfg_d;
  logic [PER_W-1:0]     step_q, step_d;
  logic                 blink_q, blink_d;
  logic [PWM_W-1:0]     duty_q, duty_d;
  logic                 dir_dn_q, dir_dn_d;
  logic                 raw_q, raw_d;
  logic [PER_W_MAX-1:0] eff_s;
  logic                 step_ev_s;

  // Next-state: a write overrides (and swallows) any coincident tick.
  always_comb begin
    cfg_d     = cfg_q;
    step_d    = step_q;
    blink_d   = blink_q;
    duty_d    = duty_q;
    dir_dn_d  = dir_dn_q;
    eff_s     = (cfg_q.period == '0) ? PER_W_MAX'(1) : cfg_q.period;
    step_ev_s = (PER_W_MAX'(step_q) == (eff_s - PER_W_MAX'(1)));
    if (wr_i) begin
      cfg_d.mode   = mode_i;
      cfg_d.period = PER_W_MAX'(period_i);
      step_d       = '0;
      blink_d      = 1'b0;
      duty_d       = '0;
      dir_dn_d     = 1'b0;
    end else if (tick_i && step_ev_s) begin
      step_d  = '0;
      blink_d = ~blink_q;
      // At either end of the ramp the step only reverses direction.
      if (!dir_dn_q) begin
        if (duty_q == DUTY_MAX) begin
          dir_dn_d = 1'b1;
        end else begin
          duty_d = duty_q + PWM_W'(1);
        end
      end else begin
        if (duty_q == '0) begin
          dir_dn_d = 1'b0;
        end else begin
          duty_d = duty_q - PWM_W'(1);
        end
      end
    end else if (tick_i) begin
      step_d = step_q + PER_W'(1);
    end else begin
      step_d = step_q;
    end

    case (cfg_q.mode)
      MODE_OFF:     raw_d = 1'b0;
      MODE_ON:      raw_d = 1'b1;
      MODE_BLINK:   raw_d = blink_q;
      MODE_BREATHE: raw_d = (pwm_cnt_i < duty_q);
      default:      raw_d = 1'b0;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_q    <= '{mode: DEFAULT_MODE, period: PER_W_MAX'(DEFAULT_PERIOD)};
      step_q   <= '0;
      blink_q  <= 1'b0;
      duty_q   <= '0;
      dir_dn_q <= 1'b0;
      raw_q    <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      step_q   <= step_d;
      blink_q  <= blink_d;
      duty_q   <= duty_d;
      dir_dn_q <= dir_dn_d;
      raw_q    <= raw_d;
    end
  end

  assign raw_on_o = raw_q;

endmodule

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED controller: shared tick prescaler and PWM counter, write
// decode to NUM_LED independent channels, and the registered LED drive.
module led_ctrl_multi
  import led_ctrl_pkg::*;
#(
  parameter int               NUM_LED        = 4,
  parameter int               TICK_DIV       = 50000,
  parameter int               PER_W          = 16,
  parameter int               PWM_W          = 8,
  parameter mode_t            DEFAULT_MODE   = MODE_BLINK,
  parameter logic [PER_W-1:0] DEFAULT_PERIOD = PER_W'(500),
  parameter bit               LED_ACTIVE_LOW = 1'b0
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  led_ctrl_multi_if.slave    cfg,
  output logic [NUM_LED-1:0] led_pin
);

  localparam int               PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [NUM_LED-1:0] LED_INACTIVE = {NUM_LED{LED_ACTIVE_LOW}};

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               tick_q, tick_d;
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_LED-1:0] raw_s;
  logic [NUM_LED-1:0] wr_s;

  // Prescaler, tick pulse, PWM frame counter and output polarity.
  always_comb begin
    if (pre_q == PRE_LAST) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end else begin
      pre_d  = pre_q + PRE_W'(1);
      tick_d = 1'b0;
    end
    pwm_d = pwm_q + PWM_W'(1);
    led_d = raw_s ^ LED_INACTIVE;
  end

  // Shared timing registers and LED output register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
      led_q  <= LED_INACTIVE;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      pwm_q  <= pwm_d;
      led_q  <= led_d;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_LED; i++) begin : g_chan
      // Out-of-range channel indices match no decode and are dropped.
      assign wr_s[i] = cfg.cfg_wr && (cfg.cfg_ch == 4'(i));

      led_chan #(
        .PER_W         (PER_W),
        .PWM_W         (PWM_W),
        .DEFAULT_MODE  (DEFAULT_MODE),
        .DEFAULT_PERIOD(DEFAULT_PERIOD)
      ) u_chan (
        .clk_i    (sys_clk),
        .rst_n_i  (sys_rst_n),
        .tick_i   (tick_q),
        .pwm_cnt_i(pwm_q),
        .wr_i     (wr_s[i]),
        .mode_i   (cfg.cfg_mode),
        .period_i (cfg.cfg_period),
        .raw_on_o (raw_s[i])
      );
    end
  endgenerate

  assign led_pin = led_q;

endmodule
